// File: rtl/fpga_config_loader.sv
// Tile configuration master: decodes ADDR/D0..D3 byte packets into single-cycle config writes.
// Define CONFIG_CRC_EN to require an XOR checksum byte after D3.
module fpga_config_loader #(
  parameter int unsigned NUM_TILES = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_data,
  output logic [31:0]          config_data,
  output logic [NUM_TILES-1:0] config_en,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  typedef enum logic [2:0] {
    S_ADDR,
    S_DATA,
`ifdef CONFIG_CRC_EN
    S_CHK,
`endif
    S_WRITE,
    S_DONE
  } state_t;

  state_t               state, state_next;
  logic [7:0]           addr;
  logic [1:0]           count;
  logic [31:0]          shadow, shadow_next;
  logic                 accept, last_byte, addr_ok, pkt_ok;
  logic [NUM_TILES-1:0] strobe;

  assign accept  = in_valid && in_ready;
  assign addr_ok = ({1'b0, addr} < 9'(NUM_TILES));

  always_comb begin
    shadow_next = shadow;
    if (state == S_DATA && accept) shadow_next[8*count +: 8] = in_data;
  end

`ifdef CONFIG_CRC_EN
  assign last_byte = accept && (state == S_CHK);
  assign pkt_ok    = addr_ok &&
                     (in_data == (addr ^ shadow[7:0] ^ shadow[15:8] ^ shadow[23:16] ^ shadow[31:24]));
`else
  assign last_byte = accept && (state == S_DATA) && (count == 2'd3);
  assign pkt_ok    = addr_ok;
`endif

  always_comb begin
    strobe = '0;
    for (int unsigned i = 0; i < NUM_TILES; i++) strobe[i] = (addr == 8'(i));
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_ADDR;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    unique case (state)
      S_ADDR: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_next = (in_data == 8'hFF) ? S_DONE : S_DATA;
      end
      S_DATA: begin
        in_ready = 1'b1;
        if (in_valid && count == 2'd3) begin
`ifdef CONFIG_CRC_EN
          state_next = S_CHK;
`else
          state_next = S_WRITE;
`endif
        end
      end
`ifdef CONFIG_CRC_EN
      S_CHK: begin
        in_ready = 1'b1;
        if (in_valid) state_next = S_WRITE;
      end
`endif
      S_WRITE: state_next = S_ADDR;
      S_DONE: begin
        busy = 1'b0;
        done = 1'b1;
      end
      default: state_next = S_ADDR;
    endcase
  end

  // Strobe and word are registered on the final-byte edge so both are visible during S_WRITE.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr        <= '0;
      count       <= '0;
      shadow      <= '0;
      config_data <= '0;
      config_en   <= '0;
      error       <= 1'b0;
    end else begin
      config_en <= '0;
      if (accept && state == S_ADDR) begin
        addr  <= in_data;
        count <= '0;
      end
      if (accept && state == S_DATA) begin
        shadow <= shadow_next;
        count  <= count + 2'd1;
      end
      if (last_byte) begin
        if (pkt_ok) begin
          config_en   <= strobe;
          config_data <= shadow_next;
        end else begin
          error <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fpga_config_loader.sv
// Self-checking bench for fpga_config_loader: directed packets plus randomized packet
// streams compared every cycle against a packet-level reference model.
module tb_fpga_config_loader;
  localparam int unsigned NT = 8;
`ifdef CONFIG_CRC_EN
  localparam bit CRC = 1'b1;
`else
  localparam bit CRC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = '0;
  logic          in_ready;
  logic [31:0]   config_data;
  logic [NT-1:0] config_en;
  logic          busy, done, error;

  fpga_config_loader #(.NUM_TILES(NT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .config_data(config_data), .config_en(config_en),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Reference model: tracks packet position and predicts per-cycle outputs.
  int          cyc = 0;
  int          pos = 0;
  logic [7:0]  m_addr = '0;
  logic [7:0]  m_bytes [4];
  int          write_at = -1;
  bit          write_ok = 1'b0;
  logic [31:0] write_word = '0;
  logic [31:0] m_data = '0;
  bit          m_err = 1'b0;
  int          done_at = 1 << 30;

  task automatic model_reset();
    pos = 0; write_at = -1; m_data = '0; m_err = 1'b0; done_at = 1 << 30;
  endtask

  task automatic model_finish(input bit crc_ok);
    write_at   = cyc + 1;
    write_ok   = crc_ok && (m_addr < NT);
    write_word = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
    pos        = 0;
  endtask

  task automatic model_accept(input logic [7:0] b);
    if (pos == 0) begin
      if (b == 8'hFF) done_at = cyc + 1;
      else begin m_addr = b; pos = 1; end
    end else if (pos <= 4) begin
      m_bytes[pos-1] = b;
      pos++;
      if (!CRC && pos == 5) model_finish(1'b1);
    end else begin
      model_finish(b == (m_addr ^ m_bytes[0] ^ m_bytes[1] ^ m_bytes[2] ^ m_bytes[3]));
    end
  endtask

  task automatic check_cycle();
    logic [NT-1:0] en_exp;
    bit wr, dn;
    en_exp = '0;
    wr = (write_at == cyc);
    dn = (cyc >= done_at);
    if (wr) begin
      if (write_ok) begin en_exp[m_addr] = 1'b1; m_data = write_word; end
      else m_err = 1'b1;
    end
    check("config_en", 64'(config_en), 64'(en_exp));
    check("config_data", 64'(config_data), 64'(m_data));
    check("error", 64'(error), 64'(m_err));
    check("done", 64'(done), 64'(dn));
    check("in_ready", 64'(in_ready), 64'(!wr && !dn));
    check("busy", 64'(busy), 64'(wr || pos != 0));
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    check_cycle();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input int max_wait, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_wait && !ok; i++) begin
      in_valid = 1'b1;
      in_data  = b;
      if (in_ready) begin model_accept(b); ok = 1'b1; end
      tick();
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_pkt(input logic [7:0] a, input logic [31:0] w, input int gap,
                          input logic [7:0] crc_delta);
    logic [7:0] bytes [6];
    bit ok;
    bytes[0] = a;
    for (int i = 0; i < 4; i++) bytes[i+1] = w[8*i +: 8];
    bytes[5] = a ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24] ^ crc_delta;
    for (int i = 0; i < (CRC ? 6 : 5); i++) begin
      idle(gap);
      send_byte(bytes[i], 4, ok);
      check("accept", 64'(ok), 64'd1);
    end
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset    = 1'b1;
    model_reset();
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    bit ok;
    model_reset();
    tick();
    tick();
    reset = 1'b0;
    idle(1);

    send_pkt(8'h02, 32'h12345678, 0, 8'h00);
    idle(3);
    send_pkt(8'h02, 32'h12345678, 3, 8'h00);
    idle(3);
    send_pkt(8'h10, 32'hDDCCBBAA, 0, 8'h00);
    send_pkt(8'h00, 32'h00000001, 0, 8'h00);
    idle(2);

    send_byte(8'h05, 4, ok);
    send_byte(8'hEF, 4, ok);
    send_byte(8'hBE, 4, ok);
    do_reset();
    send_pkt(8'h01, 32'hDEADBEEF, 0, 8'h00);
    idle(2);

    send_pkt(8'h02, 32'h04030201, 0, 8'h00);
    send_pkt(8'h02, 32'h04030201, 0, 8'h01);
    idle(2);

    for (int n = 0; n < 60; n++) begin
      logic [7:0] a;
      a = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(NT, 254)) : 8'($urandom_range(0, NT - 1));
      if ($urandom_range(0, 11) == 0) begin
        send_byte(a, 4, ok);
        for (int k = 0; k < int'($urandom_range(0, 3)); k++) send_byte(8'($urandom), 4, ok);
        do_reset();
      end else begin
        send_pkt(a, $urandom, $urandom_range(0, 2),
                 ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00);
      end
      idle($urandom_range(0, 1));
    end

    send_byte(8'hFF, 4, ok);
    check("accept_ff", 64'(ok), 64'd1);
    send_byte(8'h03, 3, ok);
    check("blocked_after_done", 64'(ok), 64'd0);
    send_byte(8'h11, 3, ok);
    send_byte(8'h22, 3, ok);
    send_byte(8'h33, 3, ok);
    send_byte(8'h44, 3, ok);
    check("blocked_after_done", 64'(ok), 64'd0);
    idle(3);
    do_reset();
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
